fanout_fork_buffered: RTL and testbench
=======================================

FANOUT_FORK_BUFFERED -- requirements
Module: fanout_fork_buffered

Interface
REQ-001 The module SHALL have parameter NUM_OUT, default 9, giving the number of consumer channels (legal 1..32).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, giving the token data width.
REQ-003 The module SHALL have parameter EAGER, default 1: 1 = per-consumer independent delivery; 0 = all-or-nothing delivery.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 clk_en  input  1  state-advance enable.
REQ-008 flush  input  1  synchronous clear of buffered token.
REQ-009 cfg_en  input  NUM_OUT  static per-consumer enable.
REQ-010 in_valid  input  1  producer token valid.
REQ-011 in_data  input  DATA_WIDTH  producer token data.
REQ-012 in_sel  input  NUM_OUT  per-token destination mask.
REQ-013 in_ready  output  1  module accepts token.
REQ-014 out_valid  output  NUM_OUT  per-consumer valid.
REQ-015 out_data  output  DATA_WIDTH  buffered token data, shared by all consumers.
REQ-016 out_ready  input  NUM_OUT  per-consumer ready.
REQ-017 busy  output  1  token held in buffer.
REQ-018 drop_count  output  16  tokens discarded with empty target set.

Function
REQ-019 State: buf_valid, buf_data, tgt[NUM_OUT], sent[NUM_OUT], drop_count.
REQ-020 Accept: in_fire = in_valid & in_ready; on in_fire, tgt <= in_sel & cfg_en and buf_data <= in_data.
REQ-021 Target latched at accept; cfg_en changes after accept SHALL NOT affect the held token.
REQ-022 EAGER=1: out_valid[i] = buf_valid & tgt[i] & ~sent[i].
REQ-023 EAGER=0: out_valid[i] = buf_valid & tgt[i] & all_rdy, where all_rdy = AND over i of (~tgt[i] | out_ready[i]); sent stays 0.
REQ-024 fire[i] = out_valid[i] & out_ready[i]; each consumer SHALL receive each token exactly once.
REQ-025 done = buf_valid & ((tgt & ~sent & ~fire) == 0).
REQ-026 EAGER=1: sent <= done ? 0 : (sent | fire).
REQ-027 in_ready = clk_en & ~flush & (~buf_valid | done); back-to-back tokens SHALL sustain 1 token/cycle when all targets are ready.
REQ-028 Latency: token accepted in cycle N SHALL present out_valid in cycle N+1, never combinationally in cycle N.
REQ-029 Empty target (in_sel & cfg_en == 0) on in_fire: token dropped, buf_valid SHALL NOT set, drop_count increments, saturating at 16'hFFFF.
REQ-030 buf_valid next = in_fire & nonempty target ? 1 : (done ? 0 : buf_valid).
REQ-031 Simultaneous done and in_fire: new token SHALL load in the same edge, with sent cleared.
REQ-032 clk_en = 0: all state frozen, out_valid = 0, in_ready = 0.
REQ-033 flush = 1 (with clk_en = 1): buf_valid, tgt and sent cleared next edge; out_valid forced 0 that cycle; drop_count retained.
REQ-034 busy = buf_valid; out_data = buf_data whenever buf_valid.

Reset
REQ-035 rst = 1 SHALL immediately clear buf_valid, tgt, sent, buf_data and drop_count, independent of clk.
REQ-036 During rst: out_valid = 0, in_ready = 0, busy = 0, drop_count = 0.
REQ-037 Reset asserted mid-token SHALL discard the token without any out_valid afterwards.

Verification
REQ-038 EAGER=1, NUM_OUT=3, cfg_en=3'b111, in_sel=3'b101, data 0xA5; out_ready[0]=1, out_ready[2]=0 for 3 cycles, then 1 -> ch0 fires once in cycle N+1, ch2 fires once in cycle N+4, ch1 never valid, in_ready low until ch2 fires.
REQ-039 EAGER=0, same stimulus -> no fire until cycle N+4, then ch0 and ch2 fire in the same cycle.
REQ-040 Stream of 8 tokens, all out_ready=1, in_sel=all-ones -> 8 tokens delivered in 8 consecutive cycles, in_ready constantly 1.
REQ-041 in_sel=3'b010, cfg_en=3'b101 -> token dropped, busy stays 0, drop_count 0->1; 65540 such tokens -> drop_count = 16'hFFFF.
REQ-042 Token held with ch1 pending; assert flush one cycle -> busy=0 next cycle, ch1 never fires, drop_count unchanged.
REQ-043 Token held; assert rst asynchronously between edges -> out_valid and busy drop to 0 before the next edge; after release in_ready=1.

Source files
------------

// File: rtl/fanout_fork_buffered.sv
// fanout_fork_buffered: one-token buffer forking each accepted token to a per-token
// subset of consumers, with eager or all-or-nothing delivery.
module fanout_fork_buffered #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 32,
    parameter int EAGER      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [NUM_OUT-1:0]    cfg_en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NUM_OUT-1:0]    in_sel,
    output logic                  in_ready,
    output logic [NUM_OUT-1:0]    out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic                  busy,
    output logic [15:0]           drop_count
);
    logic                  buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [NUM_OUT-1:0]    tgt_q, tgt_d, sent_q, sent_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic [NUM_OUT-1:0]    fire, in_tgt;
    logic                  live, all_rdy, done, in_fire;

    always_comb begin
        live      = clk_en & ~flush & ~rst;
        all_rdy   = &(~tgt_q | out_ready);
        out_valid = (live & buf_valid_q) ?
                    ((EAGER != 0) ? (tgt_q & ~sent_q) : (all_rdy ? tgt_q : '0)) : '0;
        fire      = out_valid & out_ready;
        done      = buf_valid_q & ((tgt_q & ~sent_q & ~fire) == '0);
        in_ready  = live & (~buf_valid_q | done);
        in_fire   = in_valid & in_ready;
        in_tgt    = in_sel & cfg_en;
    end

    // A token whose target set is empty is counted and never enters the buffer.
    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        tgt_d        = tgt_q;
        sent_d       = sent_q;
        drop_count_d = drop_count_q;
        if (clk_en && flush) begin
            buf_valid_d = 1'b0;
            tgt_d       = '0;
            sent_d      = '0;
        end else if (clk_en) begin
            buf_valid_d  = (in_fire & (in_tgt != '0)) | (buf_valid_q & ~done);
            buf_data_d   = in_fire ? in_data : buf_data_q;
            tgt_d        = in_fire ? in_tgt : tgt_q;
            sent_d       = (EAGER == 0 || done || in_fire) ? '0 : (sent_q | fire);
            drop_count_d = (in_fire && in_tgt == '0 && drop_count_q != 16'hFFFF) ?
                           drop_count_q + 16'd1 : drop_count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            tgt_q        <= '0;
            sent_q       <= '0;
            drop_count_q <= '0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            tgt_q        <= tgt_d;
            sent_q       <= sent_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign busy       = buf_valid_q;
    assign out_data   = buf_data_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_fanout_fork_buffered.sv
// tb_fanout_fork_buffered: directed checks of an eager and an all-or-nothing
// instance driven by identical stimulus.
module tb_fanout_fork_buffered;
    logic        clk = 1'b0;
    logic        rst, clk_en, flush, in_valid;
    logic [2:0]  cfg_en, in_sel, out_ready;
    logic [31:0] in_data;
    logic        e_in_ready, l_in_ready, e_busy, l_busy;
    logic [2:0]  e_out_valid, l_out_valid;
    logic [31:0] e_out_data, l_out_data;
    logic [15:0] e_drop, l_drop;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fanout_fork_buffered #(.NUM_OUT(3), .DATA_WIDTH(32), .EAGER(1)) u_eager (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(e_in_ready),
        .out_valid(e_out_valid), .out_data(e_out_data), .out_ready(out_ready),
        .busy(e_busy), .drop_count(e_drop)
    );

    fanout_fork_buffered #(.NUM_OUT(3), .DATA_WIDTH(32), .EAGER(0)) u_lazy (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(l_in_ready),
        .out_valid(l_out_valid), .out_data(l_out_data), .out_ready(out_ready),
        .busy(l_busy), .drop_count(l_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        cfg_en = 3'b111; in_sel = 3'b000; out_ready = 3'b000; in_data = 32'h0;
        #3;
        chk("rst_busy", {31'd0, e_busy}, 32'd0);
        chk("rst_in_ready", {31'd0, e_in_ready}, 32'd0);
        chk("rst_drop", {16'd0, e_drop}, 32'd0);
        chk("rst_out_valid", {29'd0, e_out_valid}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, e_in_ready}, 32'd1);

        // Partial fan-out: ch0 ready, ch2 stalled three cycles
        tick();
        in_valid = 1'b1; in_sel = 3'b101; in_data = 32'hA5; out_ready = 3'b001;
        #1;
        chk("n_in_ready", {31'd0, e_in_ready}, 32'd1);
        chk("n_no_comb_valid", {29'd0, e_out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("n1_e_valid", {29'd0, e_out_valid}, 32'h5);
        chk("n1_e_data", e_out_data, 32'hA5);
        chk("n1_e_in_ready", {31'd0, e_in_ready}, 32'd0);
        chk("n1_l_valid", {29'd0, l_out_valid}, 32'd0);
        tick(); #1;
        chk("n2_e_valid", {29'd0, e_out_valid}, 32'h4);
        chk("n2_l_valid", {29'd0, l_out_valid}, 32'd0);
        tick(); #1;
        chk("n3_e_valid", {29'd0, e_out_valid}, 32'h4);
        chk("n3_e_in_ready", {31'd0, e_in_ready}, 32'd0);
        chk("n3_l_in_ready", {31'd0, l_in_ready}, 32'd0);
        tick();
        out_ready = 3'b101;
        #1;
        chk("n4_e_valid", {29'd0, e_out_valid}, 32'h4);
        chk("n4_e_in_ready", {31'd0, e_in_ready}, 32'd1);
        chk("n4_l_valid", {29'd0, l_out_valid}, 32'h5);
        chk("n4_l_in_ready", {31'd0, l_in_ready}, 32'd1);
        tick(); #1;
        chk("n5_e_busy", {31'd0, e_busy}, 32'd0);
        chk("n5_l_busy", {31'd0, l_busy}, 32'd0);
        chk("n5_e_valid", {29'd0, e_out_valid}, 32'd0);

        // Back-to-back stream of 8 tokens
        out_ready = 3'b111; in_sel = 3'b111;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 32'(k + 1);
            #1;
            chk("strm_e_in_ready", {31'd0, e_in_ready}, 32'd1);
            chk("strm_l_in_ready", {31'd0, l_in_ready}, 32'd1);
            if (k > 0) begin
                chk("strm_e_valid", {29'd0, e_out_valid}, 32'h7);
                chk("strm_e_data", e_out_data, 32'(k));
                chk("strm_l_valid", {29'd0, l_out_valid}, 32'h7);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("strm_last_valid", {29'd0, e_out_valid}, 32'h7);
        chk("strm_last_data", e_out_data, 32'd8);
        tick(); #1;
        chk("strm_end_busy", {31'd0, e_busy}, 32'd0);

        // Single dropped token
        cfg_en = 3'b101; in_sel = 3'b010; in_valid = 1'b1; out_ready = 3'b000;
        #1;
        chk("drop_pre", {16'd0, e_drop}, 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("drop_busy", {31'd0, e_busy}, 32'd0);
        chk("drop_cnt1", {16'd0, e_drop}, 32'd1);
        chk("drop_l_cnt1", {16'd0, l_drop}, 32'd1);

        // Flush a held token with ch1 pending
        cfg_en = 3'b111; in_sel = 3'b010; in_data = 32'h5C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("fl_e_valid", {29'd0, e_out_valid}, 32'h2);
        chk("fl_busy", {31'd0, e_busy}, 32'd1);
        tick();
        flush = 1'b1; out_ready = 3'b010;
        #1;
        chk("fl_forced_valid", {29'd0, e_out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, e_in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_after_busy", {31'd0, e_busy}, 32'd0);
        chk("fl_after_valid", {29'd0, e_out_valid}, 32'd0);
        chk("fl_drop_kept", {16'd0, e_drop}, 32'd1);

        // clk_en freeze and cfg_en change after accept
        in_sel = 3'b011; in_data = 32'h77; in_valid = 1'b1; out_ready = 3'b000;
        tick();
        in_valid = 1'b0; cfg_en = 3'b001; clk_en = 1'b0; out_ready = 3'b111;
        #1;
        chk("frz_valid", {29'd0, e_out_valid}, 32'd0);
        chk("frz_in_ready", {31'd0, e_in_ready}, 32'd0);
        tick(); tick(); #1;
        chk("frz_busy", {31'd0, e_busy}, 32'd1);
        tick();
        clk_en = 1'b1;
        #1;
        chk("cfg_late_valid", {29'd0, e_out_valid}, 32'h3);
        chk("cfg_late_l_valid", {29'd0, l_out_valid}, 32'h3);
        tick(); #1;
        chk("frz_done_busy", {31'd0, e_busy}, 32'd0);

        // Drop saturation: 65539 more empty-target tokens
        cfg_en = 3'b101; in_sel = 3'b010; in_valid = 1'b1;
        repeat (65539) @(posedge clk);
        #2;
        in_valid = 1'b0;
        #1;
        chk("drop_sat", {16'd0, e_drop}, 32'hFFFF);
        chk("drop_l_sat", {16'd0, l_drop}, 32'hFFFF);
        chk("drop_sat_busy", {31'd0, e_busy}, 32'd0);

        // Asynchronous reset mid-token
        cfg_en = 3'b111; in_sel = 3'b110; in_data = 32'h3C; in_valid = 1'b1; out_ready = 3'b000;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ar_busy_pre", {31'd0, e_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, e_busy}, 32'd0);
        chk("ar_valid", {29'd0, e_out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, e_in_ready}, 32'd0);
        chk("ar_drop", {16'd0, e_drop}, 32'd0);
        tick();
        rst = 1'b0; out_ready = 3'b111;
        #1;
        chk("ar_rel_in_ready", {31'd0, e_in_ready}, 32'd1);
        chk("ar_rel_valid", {29'd0, e_out_valid}, 32'd0);
        tick(); #1;
        chk("ar_rel_valid2", {29'd0, e_out_valid}, 32'd0);
        chk("ar_rel_l_valid", {29'd0, l_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
